// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port DRAM arbiter.
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif

package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W      = `DRAM_ADDRESS_SIZE;
  localparam int unsigned DEF_WORD_W      = `DRAM_WORD_SIZE;
  localparam int unsigned DEF_BLOCK_WORDS = `DRAM_BLOCK_SIZE;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  typedef logic [DEF_WORD_W-1:0] blk_t [DEF_BLOCK_WORDS];

endpackage

// File: rtl/mem_arb_port.sv
// Per-requester holding register: captures a one-cycle request pulse and
// keeps it pending until the arbiter clears it on completion.
module mem_arb_port
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned WORD_W      = DEF_WORD_W,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic              rw,
  input  logic [WORD_W-1:0] data_in [BLOCK_WORDS],
  input  logic              clear,
  output logic              pend,
  output logic [ADDR_W-1:0] addr,
  output logic              rw_out,
  output logic [WORD_W-1:0] data_out [BLOCK_WORDS],
  output logic              overflow
);

  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [WORD_W-1:0] data_q [BLOCK_WORDS];
  logic [WORD_W-1:0] data_d [BLOCK_WORDS];

  // A pulse arriving while the stored request is still live is dropped;
  // a pulse in the clearing cycle re-arms the register (set wins).
  always_comb begin
    overflow = valid && pend_q && !clear;
    pend_d   = pend_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    data_d   = data_q;
    if (clear) begin
      pend_d = 1'b0;
    end
    if (valid && !overflow) begin
      pend_d = 1'b1;
      addr_d = address;
      rw_d   = rw;
      data_d = data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= 1'b0;
      addr_q <= '0;
      rw_q   <= 1'b0;
      data_q <= '{default: '0};
    end else begin
      pend_q <= pend_d;
      addr_q <= addr_d;
      rw_q   <= rw_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    pend     = pend_q;
    addr     = addr_q;
    rw_out   = rw_q;
    data_out = data_q;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the DRAM port between the data-cache (D) and instruction-cache (I)
// controllers; one transaction outstanding, round-robin on simultaneous requests.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned WORD_W      = DEF_WORD_W,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [WORD_W-1:0] d_data_in [BLOCK_WORDS],
  input  logic              d_rw,
  input  logic              d_valid,
  output logic [WORD_W-1:0] d_data_out [BLOCK_WORDS],
  output logic              d_ready,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_valid,
  output logic [WORD_W-1:0] i_data_out [BLOCK_WORDS],
  output logic              i_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_data_out [BLOCK_WORDS],
  output logic              mem_rw,
  output logic              mem_valid,
  input  logic [WORD_W-1:0] mem_data_in [BLOCK_WORDS],
  input  logic              mem_ready,
  output logic              err
);

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;
  logic   err_q, err_d;

  logic              d_pend, i_pend;
  logic [ADDR_W-1:0] d_addr, i_addr;
  logic              d_rw_h, i_rw_h;
  logic [WORD_W-1:0] d_blk [BLOCK_WORDS];
  logic [WORD_W-1:0] i_blk [BLOCK_WORDS];
  logic [WORD_W-1:0] zero_blk [BLOCK_WORDS];
  logic              d_clear, i_clear;
  logic              d_ovf, i_ovf;
  logic              sel, drive;

  always_comb zero_blk = '{default: '0};

  mem_arb_port #(
    .ADDR_W      (ADDR_W),
    .WORD_W      (WORD_W),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_port_d (
    .clock    (clock),
    .reset    (reset),
    .valid    (d_valid),
    .address  (d_address),
    .rw       (d_rw),
    .data_in  (d_data_in),
    .clear    (d_clear),
    .pend     (d_pend),
    .addr     (d_addr),
    .rw_out   (d_rw_h),
    .data_out (d_blk),
    .overflow (d_ovf)
  );

  // Instruction side is read-only: direction and write data are tied low.
  mem_arb_port #(
    .ADDR_W      (ADDR_W),
    .WORD_W      (WORD_W),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_port_i (
    .clock    (clock),
    .reset    (reset),
    .valid    (i_valid),
    .address  (i_address),
    .rw       (1'b0),
    .data_in  (zero_blk),
    .clear    (i_clear),
    .pend     (i_pend),
    .addr     (i_addr),
    .rw_out   (i_rw_h),
    .data_out (i_blk),
    .overflow (i_ovf)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    sel          = owner_q;
    drive        = 1'b0;
    mem_valid    = 1'b0;
    d_ready      = 1'b0;
    i_ready      = 1'b0;
    d_clear      = 1'b0;
    i_clear      = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_pend || i_pend) begin
          if (d_pend && i_pend) begin
            sel = (last_grant_q == PORT_D) ? PORT_I : PORT_D;
          end else begin
            sel = d_pend ? PORT_D : PORT_I;
          end
          drive        = 1'b1;
          mem_valid    = 1'b1;
          owner_d      = sel;
          last_grant_d = sel;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        drive = 1'b1;
        if (mem_ready) begin
          state_d = IDLE;
          if (owner_q == PORT_D) begin
            d_ready = 1'b1;
            d_clear = 1'b1;
          end else begin
            i_ready = 1'b1;
            i_clear = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    mem_address  = '0;
    mem_rw       = 1'b0;
    mem_data_out = '{default: '0};
    if (drive) begin
      if (sel == PORT_D) begin
        mem_address  = d_addr;
        mem_rw       = d_rw_h;
        mem_data_out = d_blk;
      end else begin
        mem_address  = i_addr;
        mem_rw       = i_rw_h;
        mem_data_out = i_blk;
      end
    end

    err_d = err_q | d_ovf | i_ovf;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= PORT_D;
      last_grant_q <= PORT_I;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    err        = err_q;
    d_data_out = mem_data_in;
    i_data_out = mem_data_in;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: issue scoreboard, table of single-port transactions,
// and directed sequences for ties, re-requests, reset mid-flight and overflow.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned WW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned FW = AW * 0 + WW * BW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] d_address = '0;
  logic [WW-1:0] d_data_in [BW];
  logic          d_rw = 1'b0;
  logic          d_valid = 1'b0;
  logic [WW-1:0] d_data_out [BW];
  logic          d_ready;
  logic [AW-1:0] i_address = '0;
  logic          i_valid = 1'b0;
  logic [WW-1:0] i_data_out [BW];
  logic          i_ready;
  logic [AW-1:0] mem_address;
  logic [WW-1:0] mem_data_out [BW];
  logic          mem_rw;
  logic          mem_valid;
  logic [WW-1:0] mem_data_in [BW];
  logic          mem_ready;
  logic          err;

  logic        resp_ready = 1'b0;
  logic        manual_ready = 1'b0;
  logic        resp_en = 1'b0;
  int unsigned resp_lat = 1;
  assign mem_ready = resp_ready | manual_ready;

  mem_arbiter #(
    .ADDR_W      (AW),
    .WORD_W      (WW),
    .BLOCK_WORDS (BW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .d_address    (d_address),
    .d_data_in    (d_data_in),
    .d_rw         (d_rw),
    .d_valid      (d_valid),
    .d_data_out   (d_data_out),
    .d_ready      (d_ready),
    .i_address    (i_address),
    .i_valid      (i_valid),
    .i_data_out   (i_data_out),
    .i_ready      (i_ready),
    .mem_address  (mem_address),
    .mem_data_out (mem_data_out),
    .mem_rw       (mem_rw),
    .mem_valid    (mem_valid),
    .mem_data_in  (mem_data_in),
    .mem_ready    (mem_ready),
    .err          (err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          port;
    logic          rw;
    logic [AW-1:0] addr;
    logic [FW-1:0] data;
  } exp_t;

  typedef struct packed {
    logic          port;
    logic [AW-1:0] addr;
    logic          rw_in;
    logic [WW-1:0] seed;
    logic [3:0]    lat;
    logic          exp_rw;
  } vec_t;

  exp_t        exp_q [$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        owner_valid = 1'b0;
  logic        exp_owner = 1'b0;

  function automatic logic [FW-1:0] flat(input logic [WW-1:0] b [BW]);
    logic [FW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < BW; k++) r[k*WW +: WW] = b[k];
    return r;
  endfunction

  function automatic logic [FW-1:0] blk_of(input logic [WW-1:0] seed);
    logic [FW-1:0] r;
    for (int unsigned k = 0; k < BW; k++) r[k*WW +: WW] = seed + WW'(k);
    return r;
  endfunction

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_d(input logic [AW-1:0] a, input logic rw, input logic [WW-1:0] seed);
    d_valid   = 1'b1;
    d_address = a;
    d_rw      = rw;
    for (int unsigned k = 0; k < BW; k++) d_data_in[k] = seed + WW'(k);
  endtask

  task automatic set_i(input logic [AW-1:0] a);
    i_valid   = 1'b1;
    i_address = a;
  endtask

  task automatic clear_valids();
    d_valid = 1'b0;
    i_valid = 1'b0;
    d_rw    = 1'b0;
  endtask

  task automatic push(input logic port, input logic [AW-1:0] a, input logic rw, input logic [FW-1:0] data);
    exp_t e;
    e.port = port;
    e.rw   = rw;
    e.addr = a;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Completes whatever is in flight this cycle, together with any pulses already set.
  task automatic ready_cycle();
    manual_ready = 1'b1;
    tick();
    manual_ready = 1'b0;
    clear_valids();
  endtask

  task automatic do_reset();
    exp_q.delete();
    clear_valids();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned bound);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || owner_valid) && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL wait_idle: got timeout after %0d cycles expected completion", n);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      for (int unsigned k = 0; k < BW; k++) mem_data_in[k] = $urandom;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (resp_en && mem_valid && !reset) begin
        repeat (resp_lat) @(posedge clock);
        #1 resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        owner_valid = 1'b0;
      end else begin
        if (mem_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: mem_valid got 1 expected 0 (address %0h)", mem_address);
          end else begin
            e = exp_q.pop_front();
            chk("issue_addr", FW'(mem_address), FW'(e.addr));
            chk("issue_rw", FW'(mem_rw), FW'(e.rw));
            chk("issue_data", flat(mem_data_out), e.data);
            exp_owner   = e.port;
            owner_valid = 1'b1;
          end
        end
        if (mem_ready) begin
          chk("d_ready", FW'(d_ready), FW'(owner_valid && exp_owner == PORT_D));
          chk("i_ready", FW'(i_ready), FW'(owner_valid && exp_owner == PORT_I));
          chk("d_data_out", flat(d_data_out), flat(mem_data_in));
          chk("i_data_out", flat(i_data_out), flat(mem_data_in));
          owner_valid = 1'b0;
        end else begin
          chk("ready_quiet", FW'({d_ready, i_ready}), '0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    vecs[0] = '{port: PORT_D, addr: 32'h0000_1000, rw_in: 1'b0, seed: 32'h10, lat: 4'd1, exp_rw: 1'b0};
    vecs[1] = '{port: PORT_I, addr: 32'h0000_2040, rw_in: 1'b1, seed: 32'h20, lat: 4'd2, exp_rw: 1'b0};
    vecs[2] = '{port: PORT_D, addr: 32'hFFFF_FFF0, rw_in: 1'b1, seed: 32'hA0, lat: 4'd3, exp_rw: 1'b1};
    vecs[3] = '{port: PORT_I, addr: 32'h0000_0000, rw_in: 1'b0, seed: 32'h30, lat: 4'd5, exp_rw: 1'b0};
    vecs[4] = '{port: PORT_D, addr: 32'h8000_0004, rw_in: 1'b0, seed: 32'hFFFF_FFFE, lat: 4'd1, exp_rw: 1'b0};
    vecs[5] = '{port: PORT_I, addr: 32'h7FFF_FFFC, rw_in: 1'b0, seed: 32'h55, lat: 4'd4, exp_rw: 1'b0};

    for (int unsigned k = 0; k < BW; k++) begin
      d_data_in[k]   = '0;
      mem_data_in[k] = '0;
    end

    // Reset values and single D read
    do_reset();
    chk("rst_mem_valid", FW'(mem_valid), '0);
    chk("rst_mem_rw", FW'(mem_rw), '0);
    chk("rst_mem_address", FW'(mem_address), '0);
    chk("rst_mem_data_out", flat(mem_data_out), '0);
    chk("rst_readies", FW'({d_ready, i_ready}), '0);
    chk("rst_err", FW'(err), '0);
    tick();
    tick();
    set_d(32'h100, 1'b0, 32'h0);
    push(PORT_D, 32'h100, 1'b0, blk_of(32'h0));
    tick();
    clear_valids();
    chk("d_read_latency", FW'(mem_valid), FW'(1'b1));
    tick();
    chk("wait_no_valid", FW'(mem_valid), '0);
    tick();
    ready_cycle();
    chk("after_ready_idle", FW'(mem_valid), '0);

    // Tie after reset: D first, I on the cycle after D completes
    do_reset();
    set_d(32'h200, 1'b0, 32'h7);
    set_i(32'h300);
    push(PORT_D, 32'h200, 1'b0, blk_of(32'h7));
    push(PORT_I, 32'h300, 1'b0, '0);
    tick();
    clear_valids();
    chk("tie_latency", FW'(mem_valid), FW'(1'b1));
    tick();
    ready_cycle();
    chk("tie_i_next_valid", FW'(mem_valid), FW'(1'b1));
    chk("tie_i_next_addr", FW'(mem_address), FW'(32'h300));
    tick();
    ready_cycle();

    // Write-back then allocate re-request in the ready cycle
    set_d(32'h40, 1'b1, 32'h1);
    push(PORT_D, 32'h40, 1'b1, blk_of(32'h1));
    tick();
    clear_valids();
    chk("wb_rw", FW'(mem_rw), FW'(1'b1));
    tick();
    set_d(32'h40, 1'b0, 32'h9);
    push(PORT_D, 32'h40, 1'b0, blk_of(32'h9));
    ready_cycle();
    chk("alloc_valid", FW'(mem_valid), FW'(1'b1));
    chk("alloc_rw", FW'(mem_rw), '0);
    chk("alloc_addr", FW'(mem_address), FW'(32'h40));
    tick();
    ready_cycle();

    // I arriving during the write-back is served before D's allocate
    set_d(32'h40, 1'b1, 32'h11);
    push(PORT_D, 32'h40, 1'b1, blk_of(32'h11));
    tick();
    clear_valids();
    set_i(32'h80);
    tick();
    clear_valids();
    set_d(32'h40, 1'b0, 32'h21);
    push(PORT_I, 32'h80, 1'b0, '0);
    push(PORT_D, 32'h40, 1'b0, blk_of(32'h21));
    ready_cycle();
    chk("fair_i_addr", FW'(mem_address), FW'(32'h80));
    tick();
    ready_cycle();
    chk("fair_d_valid", FW'(mem_valid), FW'(1'b1));
    chk("fair_d_addr", FW'(mem_address), FW'(32'h40));
    tick();
    ready_cycle();

    // Reset while a transaction is in flight
    set_d(32'h600, 1'b1, 32'h44);
    push(PORT_D, 32'h600, 1'b1, blk_of(32'h44));
    tick();
    clear_valids();
    tick();
    exp_q.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw_mem_valid", FW'(mem_valid), '0);
    chk("rstw_mem_address", FW'(mem_address), '0);
    chk("rstw_mem_rw", FW'(mem_rw), '0);
    chk("rstw_mem_data_out", flat(mem_data_out), '0);
    chk("rstw_err", FW'(err), '0);
    tick();
    manual_ready = 1'b1;
    chk("rstw_late_ready", FW'({d_ready, i_ready, mem_valid}), '0);
    tick();
    manual_ready = 1'b0;
    repeat (3) tick();

    // Overflow: second D pulse while the first is pending
    do_reset();
    set_d(32'h100, 1'b0, 32'h3);
    push(PORT_D, 32'h100, 1'b0, blk_of(32'h3));
    tick();
    set_d(32'h500, 1'b0, 32'h5);
    tick();
    clear_valids();
    chk("ovf_err_set", FW'(err), FW'(1'b1));
    chk("ovf_kept_addr", FW'(mem_address), FW'(32'h100));
    ready_cycle();
    repeat (3) tick();
    chk("ovf_err_sticky", FW'(err), FW'(1'b1));

    // Table of single-port transactions with the automatic responder
    do_reset();
    resp_en = 1'b1;
    for (int unsigned v = 0; v < 6; v++) begin
      resp_lat = int'(vecs[v].lat);
      if (vecs[v].port == PORT_D) begin
        set_d(vecs[v].addr, vecs[v].rw_in, vecs[v].seed);
        push(PORT_D, vecs[v].addr, vecs[v].exp_rw, blk_of(vecs[v].seed));
      end else begin
        set_i(vecs[v].addr);
        d_rw = vecs[v].rw_in;
        for (int unsigned k = 0; k < BW; k++) d_data_in[k] = vecs[v].seed;
        push(PORT_I, vecs[v].addr, vecs[v].exp_rw, '0);
      end
      tick();
      clear_valids();
      chk("vec_latency", FW'(mem_valid), FW'(1'b1));
      wait_idle(40);
    end
    chk("vec_err_clear", FW'(err), '0);
    resp_en = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single block-wide DRAM port between the data-cache controller (port D) and the instruction-cache controller (port I). It captures each requester's one-cycle request pulse into a per-port holding register and grants the DRAM to one owner at a time, round-robin on ties. It forwards the DRAM completion strobe only to the owner. It sits between both cache controllers and the memory model/controller; each side keeps its existing valid-pulse/ready-pulse protocol unchanged.

## Interface
- ADDR_W, default `DRAM_ADDRESS_SIZE (32): byte address width
- WORD_W, default `DRAM_WORD_SIZE (32): word width
- BLOCK_WORDS, default `DRAM_BLOCK_SIZE (4): words per block transfer
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- d_address / i_address  in  ADDR_W  request address
- d_data_in  in  WORD_W[BLOCK_WORDS]  write-back block; port I has no write data
- d_rw  in  1  1 = write; port I is read-only
- d_valid / i_valid  in  1  one-cycle request pulse
- d_data_out / i_data_out  out  WORD_W[BLOCK_WORDS]  read block, broadcast copy of mem_data_in
- d_ready / i_ready  out  1  completion pulse to the owner only
- mem_address  out  ADDR_W  granted request address
- mem_data_out  out  WORD_W[BLOCK_WORDS]  granted write block
- mem_rw  out  1  granted direction
- mem_valid  out  1  one-cycle issue pulse
- mem_data_in  in  WORD_W[BLOCK_WORDS]  DRAM read block
- mem_ready  in  1  DRAM completion pulse
- err  out  1  sticky protocol-violation flag

## Operation
- Per-port holding register: pend, addr, rw, data.
  - A valid pulse sets pend and captures the request fields at the clock edge.
  - Port I always captures rw = 0.
- FSM states: IDLE, WAIT.
- IDLE:
  - With no pend set, all mem_* outputs are 0.
  - With exactly one pend set, grant that port.
  - With both pend set, grant the port opposite last_grant.
  - On grant: drive mem_valid = 1 combinationally, drive mem_address/mem_rw/mem_data_out from the granted holding register, latch owner and last_grant, go to WAIT.
- WAIT:
  - mem_address/mem_rw/mem_data_out stay driven from the owner's register; mem_valid = 0.
  - On mem_ready: pulse <owner>_ready the same cycle (combinational), clear the owner's pend, go to IDLE.
- Simultaneous events:
  - A valid pulse on a port in the same cycle its pend clears sets pend again (set wins). This covers the dcache write-back→allocate re-request.
  - A valid pulse while that port's pend is already set and not clearing: the pulse is dropped, the stored request is kept, and err is set.
  - mem_ready in IDLE is ignored.
- Reset:
  - All pend = 0, state = IDLE, last_grant = I (so D wins the first tie), err = 0.
  - A DRAM response still in flight after reset is ignored in IDLE.
- d_data_out / i_data_out always equal mem_data_in. Consumers qualify them with their own ready.

## Timing
- Reset values: mem_valid, mem_rw, d_ready, i_ready, err = 0; mem_address, mem_data_out = 0.
- A request pulse in cycle t gives the earliest mem_valid in cycle t+1.
- mem_ready in cycle r gives <owner>_ready in cycle r, with zero added latency.
- After mem_ready in cycle r, the earliest next mem_valid is cycle r+1, including the re-request pulsed in cycle r.
- Arbiter overhead is 1 cycle per transaction. One transaction is outstanding at a time.
- Under continuous contention, grants alternate strictly D, I, D, I…

## Structure
- mem_arb_pkg:
  - state enum {IDLE, WAIT}
  - port index constants PORT_D = 0, PORT_I = 1
  - block typedef logic [WORD_W-1:0] blk_t [BLOCK_WORDS]
- Sub-module mem_arb_port: the holding register with set/clear/overflow logic, instantiated twice (I instance with write data tied 0).
- Target size: about 150–250 lines total.

## Test plan
- Single D read:
  - d_valid in cycle 5, address 0x100, rw = 0 → mem_valid in cycle 6 with address 0x100, rw = 0.
  - mem_ready in cycle 9 → d_ready = 1 in cycle 9; i_ready stays 0.
- Tie after reset:
  - d_valid (0x200) and i_valid (0x300) both in cycle 3 → mem_valid in cycle 4 with address 0x200.
  - After ready, mem_valid with address 0x300 the next cycle.
- Write-back then allocate:
  - d pulses rw = 1, address 0x40, data {1,2,3,4} → mem_data_out = {1,2,3,4}, mem_rw = 1.
  - d re-pulses rw = 0 in the ready cycle → next cycle mem_valid with rw = 0 and the same address.
- Fairness with the allocate re-request pending:
  - While the D write-back is in flight, an i_valid arrives → I is granted before D's allocate.
- Reset in WAIT:
  - reset asserted mid-transaction → all outputs 0.
  - A later mem_ready → no d_ready/i_ready pulse, and no mem_valid.
- Overflow:
  - Second d_valid (0x500) while the first (0x100) is pending → err = 1 sticky; the issued address is 0x100.
